// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants and fetch state encoding
package pipe_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INC    = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage feeding the IF/ID register
module if_fetch_unit
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            IFIDwriteEn,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirectPc,
    output logic            imemReqValid,
    input  logic            imemReqReady,
    output logic [XLEN-1:0] imemAddr,
    input  logic            imemRspValid,
    input  logic [XLEN-1:0] imemRspData,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pcNext,
    output logic            IFflush
);

    fetch_state_t    state, state_d;
    logic [XLEN-1:0] pc, pc_d;
    logic [XLEN-1:0] hold_instr, hold_d;
    logic            drop_pending, drop_d;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_tgt;
    logic            rsp_take;

    assign pc_plus4     = pc + PC_INC;
    assign redirect_tgt = redirectPc & ~32'h3;
    assign rsp_take     = imemRspValid & ~drop_pending & ~redirect;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            hold_instr   <= NOP_INSTR;
            drop_pending <= 1'b0;
        end else begin
            state        <= state_d;
            pc           <= pc_d;
            hold_instr   <= hold_d;
            drop_pending <= drop_d;
        end
    end

    always_comb begin
        state_d      = state;
        pc_d         = pc;
        hold_d       = hold_instr;
        drop_d       = drop_pending;
        imemReqValid = 1'b0;
        imemAddr     = pc;
        instr        = NOP_INSTR;
        pcNext       = pc_plus4;
        IFflush      = 1'b1;

        case (state)
            IDLE: state_d = REQ;

            REQ: begin
                imemReqValid = ~redirect;
                if (redirect) begin
                    pc_d = redirect_tgt;
                end else if (imemReqReady) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (rsp_take) begin
                    instr   = imemRspData;
                    IFflush = 1'b0;
                end
                // A redirect with no response yet must swallow the in-flight word later
                if (redirect) begin
                    pc_d = redirect_tgt;
                    if (imemRspValid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imemRspValid) begin
                    if (drop_pending) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else if (IFIDwriteEn) begin
                        pc_d    = pc_plus4;
                        state_d = REQ;
                    end else begin
                        hold_d  = imemRspData;
                        state_d = HOLD;
                    end
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_tgt;
                    state_d = REQ;
                end else begin
                    instr   = hold_instr;
                    IFflush = 1'b0;
                    if (IFIDwriteEn) begin
                        pc_d    = pc_plus4;
                        state_d = REQ;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        IFIDwriteEn;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        imemReqValid;
    logic        imemReqReady;
    logic [31:0] imemAddr;
    logic        imemRspValid;
    logic [31:0] imemRspData;
    logic [31:0] instr;
    logic [31:0] pcNext;
    logic        IFflush;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .IFIDwriteEn  (IFIDwriteEn),
        .redirect     (redirect),
        .redirectPc   (redirectPc),
        .imemReqValid (imemReqValid),
        .imemReqReady (imemReqReady),
        .imemAddr     (imemAddr),
        .imemRspValid (imemRspValid),
        .imemRspData  (imemRspData),
        .instr        (instr),
        .pcNext       (pcNext),
        .IFflush      (IFflush)
    );

    localparam logic [31:0] NOP = 32'h0000_0013;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory responder: one response, lat cycles after acceptance
    int          lat = 1;
    int          cnt = 0;
    logic [31:0] raddr = 32'h0;
    initial begin
        bit          acc;
        logic [31:0] acc_a;
        imemRspValid = 1'b0;
        imemRspData  = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            acc   = reset && imemReqValid && imemReqReady;
            acc_a = imemAddr;
            @(posedge clk);
            #1;
            if (!reset) begin
                cnt = 0;
            end else begin
                if (cnt > 0) cnt--;
                if (acc) begin
                    cnt   = lat;
                    raddr = acc_a;
                end
            end
            imemRspValid = (cnt == 1);
            imemRspData  = (cnt == 1) ? mem_word(raddr) : 32'hDEAD_BEEF;
        end
    end

    // Abstract model: pc, outstanding request, stale flag, held word
    bit          m_started, m_busy, m_stale, m_have;
    logic [31:0] m_pc, m_word;
    logic [31:0] acc_q[$];
    logic [31:0] cons_pcn[$];
    logic [31:0] cons_ins[$];
    int          cons_cyc[$];
    int          pres_cnt = 0;
    int          cyc = 0;

    initial begin
        bit          p;
        logic [31:0] w;
        bit          r;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                m_started = 0; m_busy = 0; m_stale = 0; m_have = 0;
                m_pc = 32'h0; m_word = NOP;
                chk("rst_req_valid", imemReqValid, 0);
                chk("rst_addr", imemAddr, 32'h0);
                chk("rst_instr", instr, NOP);
                chk("rst_pcnext", pcNext, 32'h4);
                chk("rst_flush", IFflush, 1);
            end else begin
                p = 0;
                w = NOP;
                if (m_started && !redirect) begin
                    if (m_have) begin
                        p = 1; w = m_word;
                    end else if (m_busy && imemRspValid && !m_stale) begin
                        p = 1; w = imemRspData;
                    end
                end
                r = m_started && !m_busy && !m_have && !redirect;
                chk("req_valid", imemReqValid, r);
                chk("addr", imemAddr, m_pc);
                chk("pcnext", pcNext, m_pc + 32'd4);
                chk("instr", instr, w);
                chk("flush", IFflush, !p);

                if (imemReqValid && imemReqReady) acc_q.push_back(imemAddr);
                if (!IFflush) pres_cnt++;
                if (!IFflush && IFIDwriteEn) begin
                    cons_pcn.push_back(pcNext);
                    cons_ins.push_back(instr);
                    cons_cyc.push_back(cyc);
                end

                if (!m_started) begin
                    m_started = 1;
                end else if (redirect) begin
                    m_pc   = redirectPc & 32'hFFFF_FFFC;
                    m_have = 0;
                    if (m_busy) begin
                        if (imemRspValid) begin
                            m_busy = 0; m_stale = 0;
                        end else begin
                            m_stale = 1;
                        end
                    end
                end else if (m_have) begin
                    if (IFIDwriteEn) begin
                        m_have = 0; m_pc = m_pc + 32'd4;
                    end
                end else if (m_busy) begin
                    if (imemRspValid) begin
                        m_busy = 0;
                        if (m_stale) m_stale = 0;
                        else if (IFIDwriteEn) m_pc = m_pc + 32'd4;
                        else begin
                            m_have = 1; m_word = imemRspData;
                        end
                    end
                end else if (imemReqReady) begin
                    m_busy = 1;
                end
            end
        end
    end

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic at_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l, input logic en, input logic rdy);
        at_pos();
        reset = 1'b0; redirect = 1'b0; redirectPc = 32'h0;
        lat = l; IFIDwriteEn = en; imemReqReady = rdy;
        at_neg();
        chk("dr_flush", IFflush, 1);
        chk("dr_instr", instr, NOP);
        at_pos();
        acc_q.delete(); cons_pcn.delete(); cons_ins.delete(); cons_cyc.delete();
        pres_cnt = 0;
        at_pos();
        reset = 1'b1;
    endtask

    task automatic wait_acc(input int n, input string name);
        for (int i = 0; i < 40; i++) begin
            if (acc_q.size() >= n) return;
            at_neg();
        end
        checks++; errors++;
        $display("FAIL %s timeout accepted %0d required %0d", name, acc_q.size(), n);
    endtask

    task automatic wait_cons(input int n, input string name);
        for (int i = 0; i < 40; i++) begin
            if (cons_pcn.size() >= n) return;
            at_neg();
        end
        checks++; errors++;
        $display("FAIL %s timeout consumed %0d required %0d", name, cons_pcn.size(), n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset = 1'b1; IFIDwriteEn = 1'b1; redirect = 1'b0; redirectPc = 32'h0;
        imemReqReady = 1'b1;
        #2 reset = 1'b0;

        // Streaming fetch, 1-cycle memory
        do_reset(1, 1'b1, 1'b1);
        wait_cons(3, "s1_cons");
        chk("s1_acc0", acc_q[0], 32'h0);
        chk("s1_acc1", acc_q[1], 32'h4);
        chk("s1_acc2", acc_q[2], 32'h8);
        chk("s1_pcn0", cons_pcn[0], 32'h4);
        chk("s1_pcn1", cons_pcn[1], 32'h8);
        chk("s1_pcn2", cons_pcn[2], 32'hC);
        chk("s1_ins0", cons_ins[0], 32'h5A5A_0000);
        chk("s1_ins2", cons_ins[2], 32'h5A5A_0008);
        chk("s1_rate", cons_cyc[2] - cons_cyc[0], 4);

        // Response held across a 3-cycle stall
        do_reset(1, 1'b0, 1'b1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            at_neg();
            if (!IFflush) begin seen = 1; break; end
        end
        chk("s2_seen", seen, 1);
        chk("s2_instr_rsp", instr, 32'h5A5A_0000);
        chk("s2_req_rsp", imemReqValid, 0);
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("s2_hold_instr", instr, 32'h5A5A_0000);
            chk("s2_hold_flush", IFflush, 0);
            chk("s2_hold_req", imemReqValid, 0);
        end
        at_pos();
        IFIDwriteEn = 1'b1;
        wait_acc(2, "s2_acc");
        chk("s2_next_addr", acc_q[1], 32'h4);
        chk("s2_cons_pcn", cons_pcn[0], 32'h4);

        // Redirect during WAIT, response two cycles later is dropped
        do_reset(3, 1'b1, 1'b1);
        wait_acc(1, "s3_acc0");
        at_pos();
        redirect = 1'b1; redirectPc = 32'h0000_0103;
        pres_cnt = 0;
        at_pos();
        redirect = 1'b0;
        wait_acc(2, "s3_acc1");
        chk("s3_next_addr", acc_q[1], 32'h0000_0100);
        chk("s3_dropped", pres_cnt, 0);
        lat = 1;

        // Redirect in the same cycle as the response
        do_reset(2, 1'b1, 1'b1);
        wait_acc(1, "s4_acc0");
        at_pos();
        at_pos();
        redirect = 1'b1; redirectPc = 32'h0000_0200;
        pres_cnt = 0;
        at_neg();
        chk("s4_flush", IFflush, 1);
        chk("s4_instr", instr, NOP);
        at_pos();
        redirect = 1'b0;
        wait_acc(2, "s4_acc1");
        chk("s4_next_addr", acc_q[1], 32'h0000_0200);
        chk("s4_never_presented", pres_cnt, 0);

        // Redirect in REQ blocks the request
        do_reset(1, 1'b1, 1'b1);
        at_pos();
        redirect = 1'b1; redirectPc = 32'h0000_0300;
        at_neg();
        chk("s5_req_blocked", imemReqValid, 0);
        chk("s5_no_accept", acc_q.size(), 0);
        at_pos();
        redirect = 1'b0;
        at_neg();
        chk("s5_req_valid", imemReqValid, 1);
        chk("s5_addr", imemAddr, 32'h0000_0300);

        // Reset asserted while waiting on a request for pc=4
        do_reset(1, 1'b1, 1'b1);
        wait_acc(1, "s6_acc0");
        at_pos();
        lat = 3;
        wait_acc(2, "s6_acc1");
        at_pos();
        chk("s6_pre_addr", imemAddr, 32'h4);
        reset = 1'b0;
        #1;
        chk("s6_rst_addr", imemAddr, 32'h0);
        chk("s6_rst_pcnext", pcNext, 32'h4);
        chk("s6_rst_instr", instr, NOP);
        chk("s6_rst_flush", IFflush, 1);
        chk("s6_rst_req", imemReqValid, 0);
        at_pos();
        acc_q.delete();
        lat = 1;
        at_pos();
        reset = 1'b1;
        wait_acc(1, "s6_acc_after");
        chk("s6_first_addr", acc_q[0], 32'h0);

        // PC wrap from 0xFFFF_FFFC
        do_reset(1, 1'b1, 1'b1);
        at_pos();
        redirect = 1'b1; redirectPc = 32'hFFFF_FFFF;
        at_pos();
        redirect = 1'b0;
        wait_cons(1, "s7_cons");
        chk("s7_pcnext_wrap", cons_pcn[0], 32'h0);
        chk("s7_instr", cons_ins[0], 32'hA5A5_FFFC);
        wait_acc(2, "s7_acc");
        chk("s7_first_addr", acc_q[0], 32'hFFFF_FFFC);
        chk("s7_wrap_addr", acc_q[1], 32'h0);

        at_pos();
        at_pos();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that writes the IF/ID pipeline register.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Presents instr, pcNext and IFflush to IF/ID, honouring the IFIDwriteEn stall from the hazard unit and branch/jump redirects from later stages.
- Holds a fetched instruction across stalls, so no re-fetch is required.

Parameters:
RESET_PC, 32'h0000_0000, PC value fetched first after reset
XLEN, 32, address/instruction width; only 32 is supported

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-low reset
IFIDwriteEn  in  1  1 = IF/ID captures this cycle (consumption); 0 = stall
redirect  in  1  branch/jump taken; highest priority
redirectPc  in  32  redirect target; bits [1:0] ignored (forced 0)
imemReqValid  out  1  request valid to instruction memory
imemReqReady  in  1  memory accepts request this cycle
imemAddr  out  32  request address (current PC)
imemRspValid  in  1  response data valid (exactly one per accepted request)
imemRspData  in  32  fetched instruction word
instr  out  32  instruction to IF/ID
pcNext  out  32  PC+4 of presented instruction, to IF/ID
IFflush  out  1  1 = presented word is a bubble and must be flushed downstream

Behaviour:
- Registers: pc, state, holdInstr, dropPending.
- Outputs are combinational from these registers and from imemRspData.
- Reset (reset low, asynchronous):
  - state=IDLE, pc=RESET_PC, dropPending=0, holdInstr=NOP.
  - Outputs during reset: imemReqValid=0, imemAddr=RESET_PC, instr=NOP (32'h0000_0013), pcNext=RESET_PC+4, IFflush=1.
  - Instruction memory shares this reset, so there are no stale responses after reset.
  - Reset mid-request aborts everything.
- Bubble output: whenever no valid instruction is presented, instr=NOP, IFflush=1, pcNext=pc+4.
- FSM states and transitions:
  - IDLE: bubble output; next cycle -> REQ.
  - REQ:
    - imemReqValid = ~redirect, imemAddr=pc, bubble output.
    - imemReqReady & imemReqValid -> WAIT.
  - WAIT:
    - Bubble output unless imemRspValid & ~dropPending & ~redirect; in that case instr=imemRspData, pcNext=pc+4, IFflush=0.
    - On a valid, non-dropped response:
      - If IFIDwriteEn=1: consumed; pc<=pc+4, go to REQ.
      - Else: holdInstr<=imemRspData, go to HOLD.
    - On a response with dropPending=1: discard it, clear dropPending, go to REQ.
  - HOLD:
    - instr=holdInstr, pcNext=pc+4, IFflush=0.
    - IFIDwriteEn=1 -> pc<=pc+4, go to REQ; otherwise stay in HOLD.
- Redirect (any state except IDLE; wins over all other events in the same cycle):
  - pc <= {redirectPc[31:2],2'b00}.
  - Output forced to bubble (IFflush=1) that cycle.
  - From REQ or HOLD -> REQ; the held instruction is discarded.
  - From WAIT with no response this cycle: set dropPending, stay in WAIT.
  - From WAIT with imemRspValid this cycle: discard the response, leave dropPending=0, go to REQ.
  - A redirect while dropPending is already set keeps dropPending=1 and updates pc.
- Stalls: IFIDwriteEn=0 never alters pc or issues extra requests. A response arriving during a stall is held, not lost.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- Request count: at most one request outstanding. The minimum fetch-to-present latency is 1 cycle after acceptance, with a same-cycle response not permitted.
- Throughput: 1 instruction per 2 cycles with a 1-cycle memory.

Decomposition:
- Shared package pipe_pkg holds:
  - XLEN.
  - NOP_INSTR = 32'h0000_0013.
  - fetch_state_t enum {IDLE, REQ, WAIT, HOLD}.
  - PC_INC = 4.
- No sub-module: the hold buffer and FSM are small and tightly coupled, so they stay inline.

Test Plan:
- Reset release, memory always ready, 1-cycle response, IFIDwriteEn=1:
  - Requests go to 0x0, 0x4, 0x8.
  - Each instruction is presented with IFflush=0, pcNext=0x4/0x8/0xC.
  - A bubble (NOP, IFflush=1) is presented between instructions.
- Response arrives while IFIDwriteEn=0 for 3 cycles:
  - instr stays equal to the response word with IFflush=0.
  - imemReqValid=0 throughout.
  - After IFIDwriteEn rises: pc+4 and a new request.
- Redirect to 0x103 while in WAIT, response arrives 2 cycles later:
  - The response is discarded (IFflush=1).
  - The next request goes to 0x100.
- Redirect in the same cycle as imemRspValid in WAIT:
  - Bubble output, that response is never presented.
  - The next request goes to the redirect target.
- redirect=1 while in REQ with imemReqReady=1:
  - imemReqValid=0, so no request is accepted.
  - The next cycle requests the new pc.
- Reset asserted mid-WAIT, then released; separately, pc=0xFFFF_FFFC consumed:
  - After reset: outputs return to the reset values immediately and the first request goes to RESET_PC.
  - Wrap case: the next request goes to 0x0.
